// File: rtl/controlador_exibicao_sequencia_pkg.sv
// Shared state codes for the sequence display controller.
// Also decodes db_estado in the control unit and in benches.
package controlador_exibicao_sequencia_pkg;

  typedef enum logic [2:0] {
    INICIAL    = 3'd0,
    ESPERA_MEM = 3'd1,
    ACENDE     = 3'd2,
    APAGA      = 3'd3,
    FIM        = 3'd4
  } estado_t;

  localparam int ESTADO_W = 4;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/controlador_exibicao_sequencia_contador_tempo.sv
// Clearable up-counter timing the on/off phases.
// Ports: clock, reset (async low), zera (clear), conta (inc), contagem.
module contador_tempo #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] contagem
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign contagem = cnt_q;

endmodule

// File: rtl/controlador_exibicao_sequencia.sv
// Walks sequence memory 0..limite, lighting each pattern then blanking.
// Ports: clock, reset(async low), iniciar, abortar, limite, dificuldade,
//   dado_memoria in; endereco, leds, ocupado, pronto, db_estado out.
module controlador_exibicao_sequencia
  import controlador_exibicao_sequencia_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int T_ON_NORMAL = 8,
  parameter int T_ON_RAPIDO = 4,
  parameter int T_OFF       = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                abortar,
  input  logic [ADDR_W-1:0]   limite,
  input  logic                dificuldade,
  input  logic [DATA_W-1:0]   dado_memoria,
  output logic [ADDR_W-1:0]   endereco,
  output logic [DATA_W-1:0]   leds,
  output logic                ocupado,
  output logic                pronto,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam int TMAX = max3(T_ON_NORMAL, T_ON_RAPIDO, T_OFF);
  localparam int TW   = $clog2(TMAX + 1);

  // Timer value on the last clock of each phase
  localparam logic [TW-1:0] ULT_ON_N = TW'(T_ON_NORMAL - 1);
  localparam logic [TW-1:0] ULT_ON_R = TW'(T_ON_RAPIDO - 1);
  localparam logic [TW-1:0] ULT_OFF  = TW'(T_OFF - 1);

  estado_t state_q;
  estado_t state_d;

  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] limite_q, limite_d;
  logic              dif_q, dif_d;
  logic [DATA_W-1:0] leds_q, leds_d;

  logic [TW-1:0] tempo;
  logic          zera, conta;
  logic          fim_on, fim_off, ultimo;
  logic          carrega, incrementa, limpa_end;
  logic          captura, pronto_c, ocupado_c;

  contador_tempo #(
    .W(TW)
  ) u_tempo (
    .clock    (clock),
    .reset    (reset),
    .zera     (zera),
    .conta    (conta),
    .contagem (tempo)
  );

  assign fim_on  = tempo == (dif_q ? ULT_ON_R : ULT_ON_N);
  assign fim_off = tempo == ULT_OFF;
  assign ultimo  = endereco_q == limite_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:    if (iniciar) state_d = ESPERA_MEM;
      ESPERA_MEM: state_d = ACENDE;
      ACENDE:     if (fim_on) state_d = APAGA;
      APAGA: begin
        if (fim_off) state_d = ultimo ? FIM : ESPERA_MEM;
      end
      FIM:        state_d = INICIAL;
      default:    state_d = INICIAL;
    endcase
    if (abortar) state_d = INICIAL;
  end

  always_comb begin
    zera       = 1'b1;
    conta      = 1'b0;
    carrega    = 1'b0;
    incrementa = 1'b0;
    limpa_end  = 1'b0;
    captura    = 1'b0;
    pronto_c   = 1'b0;
    ocupado_c  = 1'b1;
    case (state_q)
      INICIAL: begin
        ocupado_c = 1'b0;
        limpa_end = 1'b1;
        carrega   = iniciar;
      end
      ESPERA_MEM: captura = 1'b1;
      ACENDE: begin
        zera  = fim_on;
        conta = ~fim_on;
      end
      APAGA: begin
        zera       = fim_off;
        conta      = ~fim_off;
        // compare before increment so the address never wraps
        incrementa = fim_off & ~ultimo;
      end
      FIM: begin
        pronto_c  = 1'b1;
        limpa_end = 1'b1;
      end
      default: limpa_end = 1'b1;
    endcase
    if (abortar) begin
      zera       = 1'b1;
      conta      = 1'b0;
      carrega    = 1'b0;
      incrementa = 1'b0;
      captura    = 1'b0;
      pronto_c   = 1'b0;
      limpa_end  = 1'b1;
    end
  end

  always_comb begin
    endereco_d = endereco_q;
    limite_d   = limite_q;
    dif_d      = dif_q;
    leds_d     = '0;
    if (limpa_end) begin
      endereco_d = '0;
    end else if (incrementa) begin
      endereco_d = endereco_q + 1'b1;
    end
    if (carrega) begin
      limite_d = limite;
      dif_d    = dificuldade;
    end
    // LEDs load on ACENDE entry, hold through it, blank otherwise
    if (captura) begin
      leds_d = dado_memoria;
    end else if (state_d == ACENDE) begin
      leds_d = leds_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco_q <= '0;
      limite_q   <= '0;
      dif_q      <= 1'b0;
      leds_q     <= '0;
    end else begin
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      dif_q      <= dif_d;
      leds_q     <= leds_d;
    end
  end

  assign endereco  = endereco_q;
  assign leds      = leds_q;
  assign ocupado   = ocupado_c;
  assign pronto    = pronto_c;
  assign db_estado = {1'b0, state_q};

endmodule

// File: doc/controlador_exibicao_sequencia.md
# controlador_exibicao_sequencia

Sequencer for the "show sequence" phase of the memory game: after a start pulse it walks the sequence memory from address 0 up to the current round limit. For each entry it lights the stored LED pattern for an on-time, then blanks the LEDs for an off-time. It sits between the main control unit, which starts it and waits for `pronto`, and the datapath's synchronous sequence memory and LED outputs. Difficulty selects a shorter on-time.

## Interface
- `ADDR_W`, 4: memory address / limit width
- `DATA_W`, 4: memory word / LED width
- `T_ON_NORMAL`, 8: on-time in clocks, normal difficulty
- `T_ON_RAPIDO`, 4: on-time in clocks, hard difficulty
- `T_OFF`, 2: blank time in clocks between entries (≥1)

Ports:
- `clock`  in  1  single clock domain; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low; 0 forces idle immediately
- `iniciar`  in  1  start request, sampled only in INICIAL
- `abortar`  in  1  synchronous abort, wins over everything except reset
- `limite`  in  ADDR_W  last address to show; latched at start
- `dificuldade`  in  1  1 selects T_ON_RAPIDO; latched at start
- `dado_memoria`  in  DATA_W  memory read data, valid 1 clock after `endereco`
- `endereco`  out  ADDR_W  memory read address
- `leds`  out  DATA_W  LED pattern
- `ocupado`  out  1  high in every state except INICIAL
- `pronto`  out  1  one-clock pulse when the sequence has been fully shown
- `db_estado`  out  4  current state code, for hexa7seg debug display

## Operation
- States and codes: INICIAL=0, ESPERA_MEM=1, ACENDE=2, APAGA=3, FIM=4. Unused codes recover to INICIAL.
- INICIAL: `endereco`=0 and `leds`=0. If `iniciar`=1, latch `limite` and `dificuldade`, then go to ESPERA_MEM.
- ESPERA_MEM: one clock for the memory read. `leds`=0. Next state is ACENDE, and the timer is cleared.
- ACENDE: `leds` is registered from `dado_memoria` on entry and held constant. After T_ON clocks go to APAGA, with the timer cleared.
- APAGA: `leds`=0. On the last of T_OFF clocks:
  - if `endereco`==latched limit, go to FIM;
  - otherwise increment `endereco` and go to ESPERA_MEM.
- FIM: `pronto`=1 for exactly this clock, `leds`=0, then INICIAL.
- `iniciar` while `ocupado` is ignored. Changes to `limite` or `dificuldade` after start have no effect.
- `abortar`=1 in any state: next state is INICIAL, `leds`=0, `endereco`=0, no `pronto`.
- `limite`=0 shows one entry. `limite`=2^ADDR_W−1 shows all entries. `endereco` never wraps: the comparison happens before the increment.

## Timing
- Reset values: `endereco`=0, `leds`=0, `ocupado`=0, `pronto`=0, `db_estado`=0, state INICIAL, timer 0.
- Take `iniciar` sampled high at edge k. Then ESPERA_MEM runs in cycle k+1 with `endereco`=0.
- Each entry lasts P = 1 + T_ON + T_OFF clocks.
- `pronto` is high in cycle k+1+(L+1)·P, where L is the latched limit. `ocupado` falls in the following cycle.
- `leds` changes only on edges; no combinational path from `dado_memoria` to `leds`.
- `pronto` and `iniciar` may be high in the same cycle. The start is ignored, because the FSM is in FIM, not INICIAL.
- Reset deasserted mid-operation: the block resumes from INICIAL and requires a new `iniciar`.

## Structure
- Shared package or header holds the state code constants (INICIAL…FIM) so the control unit and testbench can decode `db_estado`.
- One sub-module, `contador_tempo`:
  - a clearable up-counter of width $clog2(max(T_ON_NORMAL,T_ON_RAPIDO,T_OFF)+1);
  - inputs `zera` and `conta`, output count;
  - the FSM compares the count against the selected limit.
- Address counter, latched limit, latched difficulty and the LED register live in the top of this block.

## Test plan
- L=0, normal, T_ON=8, T_OFF=2, mem[0]=4'b0010, `iniciar` pulsed at cycle 0 → `endereco`=0; `leds`=0010 in cycles 2–9 and 0 in cycles 10–11; `pronto` pulse at cycle 12.
- L=3, hard (T_ON=4), mem={1,2,4,8}, P=7 → LED pattern 1,2,4,8 in order, each held 4 clocks; `pronto` at cycle 29; `endereco` never exceeds 3.
- L=3 run with `limite` changed to 1 and `dificuldade` toggled at cycle 5 → same waveform as the unchanged run.
- `abortar` at cycle 6 during ACENDE → INICIAL at cycle 7, `leds`=0, no `pronto`; a new `iniciar` restarts at address 0.
- `reset`=0 asynchronously at mid-cycle of APAGA → all outputs 0 before the next edge; `iniciar` held during reset has no effect.
- L=15 full memory with all entries checked, plus `iniciar` pulses during busy → exactly one `pronto`, at cycle 1+16·P, no retrigger.
